traffic_countdown_ctrl: RTL and testbench

//   Upstream sequencer for traffic_display. Cycles GREEN -> YELLOW -> RED -> GREEN.

---
 rtl/traffic_countdown_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_traffic_countdown_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_countdown_ctrl
//   Phase sequencer feeding traffic_display. Cycles GREEN -> YELLOW -> RED ->
//   GREEN. Each phase shows a two-digit BCD countdown of the remaining seconds.
//   A second is CLK_DIV clock cycles, measured by an internal prescaler.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous active-high reset
//   en          in   1  run enable; 0 freezes prescaler and countdown
//   ped_req     in   1  pedestrian request (only with PED_REQ_EN)
//   sel         out  3  one-hot phase: 001 GREEN, 010 YELLOW, 100 RED
//   tens        out  4  BCD tens digit of the remaining count
//   ones        out  4  BCD ones digit of the remaining count
//   phase_done  out  1  one-cycle pulse alongside the new phase
//
// Build option
//   PED_REQ_EN  adds ped_req, the sticky ped_pend register and the PED_T
//               shortening of GREEN. Without it timing depends only on the
//               phase parameters.
// -----------------------------------------------------------------------------
module traffic_countdown_ctrl #(
    parameter int CLK_DIV  = 100_000_000,
    parameter int GREEN_T  = 35,
    parameter int YELLOW_T = 5,
    parameter int RED_T    = 30
`ifdef PED_REQ_EN
    ,
    parameter int PED_T    = 10
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
`ifdef PED_REQ_EN
    input  logic       ped_req,
`endif
    output logic [2:0] sel,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       phase_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_GREEN  = 3'b001,
        ST_YELLOW = 3'b010,
        ST_RED    = 3'b100
    } state_t;

    // Decimal 0..99 to packed {tens, ones} BCD.
    function automatic logic [7:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_T);
    localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_T);
    localparam logic [7:0] RED_BCD    = to_bcd(RED_T);

    state_t        state_r, state_s, nxt_state_s;
    logic [3:0]    tens_r, tens_s;
    logic [3:0]    ones_r, ones_s;
    logic          phase_done_r, phase_done_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [7:0]    nxt_bcd_s;
    logic          legal_s;
    logic          tick_s;
    logic          count_zero_s;
    logic          ped_load_s;

    assign tick_s       = en & (presc_r == PRESC_MAX);
    assign count_zero_s = (tens_r == 4'd0) & (ones_r == 4'd0);

`ifdef PED_REQ_EN
    localparam logic [7:0] PED_BCD = to_bcd(PED_T);

    // BCD pair back to a binary value for the PED_T comparison.
    function automatic logic [6:0] bcd_value(input logic [3:0] t, input logic [3:0] o);
        bcd_value = ({3'b000, t} * 7'd10) + {3'b000, o};
    endfunction

    logic ped_pend_r, ped_pend_s;

    // A request arriving in the tick cycle itself counts for that tick.
    assign ped_load_s = (state_r == ST_GREEN) & (ped_pend_r | ped_req) &
                        (bcd_value(tens_r, ones_r) > 7'(PED_T));

    // Sticky pending flag; the GREEN->YELLOW edge clears it unless the
    // request is still present on that edge.
    always_comb begin
        ped_pend_s = ped_pend_r | ped_req;
        if (tick_s && count_zero_s && (state_r == ST_GREEN)) begin
            ped_pend_s = ped_req;
        end else begin
            ped_pend_s = ped_pend_r | ped_req;
        end
    end

    // Pedestrian pending register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend_r <= 1'b0;
        end else begin
            ped_pend_r <= ped_pend_s;
        end
    end
`else
    assign ped_load_s = 1'b0;
`endif

    // Successor phase and its start value; unknown encodings map to GREEN.
    always_comb begin
        nxt_state_s = ST_GREEN;
        nxt_bcd_s   = GREEN_BCD;
        legal_s     = 1'b0;
        case (state_r)
            ST_GREEN: begin
                nxt_state_s = ST_YELLOW;
                nxt_bcd_s   = YELLOW_BCD;
                legal_s     = 1'b1;
            end
            ST_YELLOW: begin
                nxt_state_s = ST_RED;
                nxt_bcd_s   = RED_BCD;
                legal_s     = 1'b1;
            end
            ST_RED: begin
                nxt_state_s = ST_GREEN;
                nxt_bcd_s   = GREEN_BCD;
                legal_s     = 1'b1;
            end
            default: begin
                nxt_state_s = ST_GREEN;
                nxt_bcd_s   = GREEN_BCD;
                legal_s     = 1'b0;
            end
        endcase
    end

    // Prescaler, countdown and phase next-state logic.
    always_comb begin
        presc_s      = presc_r;
        state_s      = state_r;
        tens_s       = tens_r;
        ones_s       = ones_r;
        phase_done_s = 1'b0;

        if (en) begin
            if (tick_s) begin
                presc_s = {PW{1'b0}};
            end else begin
                presc_s = presc_r + PW'(1);
            end
        end else begin
            presc_s = presc_r;
        end

        if (!legal_s) begin
            // Corrupted phase register: restart GREEN immediately.
            state_s          = ST_GREEN;
            {tens_s, ones_s} = GREEN_BCD;
        end else if (tick_s) begin
            if (count_zero_s) begin
                // Phase and new count switch together: no mixed display.
                state_s          = nxt_state_s;
                {tens_s, ones_s} = nxt_bcd_s;
                phase_done_s     = 1'b1;
            end else if (ped_load_s) begin
`ifdef PED_REQ_EN
                {tens_s, ones_s} = PED_BCD;
`else
                {tens_s, ones_s} = {tens_r, ones_r};
`endif
            end else if (ones_r == 4'd0) begin
                ones_s = 4'd9;
                tens_s = tens_r - 4'd1;
            end else begin
                ones_s = ones_r - 4'd1;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State registers; reset wins over tick and requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_GREEN;
            tens_r       <= GREEN_BCD[7:4];
            ones_r       <= GREEN_BCD[3:0];
            phase_done_r <= 1'b0;
            presc_r      <= {PW{1'b0}};
        end else begin
            state_r      <= state_s;
            tens_r       <= tens_s;
            ones_r       <= ones_s;
            phase_done_r <= phase_done_s;
            presc_r      <= presc_s;
        end
    end

    assign sel        = state_r;
    assign tens       = tens_r;
    assign ones       = ones_r;
    assign phase_done = phase_done_r;

endmodule

// File: tb/tb_traffic_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_countdown_ctrl
//   Self-checking bench. A reference model tracks the phase index, the
//   remaining seconds as an integer and the prescaler position, and derives
//   the expected display with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_traffic_countdown_ctrl;

    localparam int DIV = 4;
    localparam int GT  = 35;
    localparam int YT  = 5;
    localparam int RT  = 30;
    localparam int PT  = 10;
`ifdef PED_REQ_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] sel;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       phase_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_countdown_ctrl #(
        .CLK_DIV (DIV),
        .GREEN_T (GT),
        .YELLOW_T(YT),
        .RED_T   (RT)
`ifdef PED_REQ_EN
        ,
        .PED_T   (PT)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef PED_REQ_EN
        .ped_req   (ped_req),
`endif
        .sel       (sel),
        .tens      (tens),
        .ones      (ones),
        .phase_done(phase_done)
    );

    // Reference model state
    int dur[3] = '{GT, YT, RT};
    int m_phase = 0;
    int m_rem = GT;
    int m_presc = 0;
    bit m_pd = 1'b0;
    bit m_pend = 1'b0;

    function automatic logic [11:0] exp_vec();
        logic [2:0] s;
        s = 3'(1 << m_phase);
        return {s, 4'(m_rem / 10), 4'(m_rem % 10), m_pd};
    endfunction

    // One clock: advance the model with the inputs seen at this edge, then
    // sample the DUT 1 time unit later.
    task automatic step();
        bit tick;
        bit eff;
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_rem = GT; m_presc = 0; m_pd = 1'b0; m_pend = 1'b0;
        end else begin
            eff  = PED_ON && (m_pend || ped_req);
            m_pd = 1'b0;
            tick = en && (m_presc == DIV - 1);
            if (en) m_presc = tick ? 0 : m_presc + 1;
            if (PED_ON && ped_req) m_pend = 1'b1;
            if (tick) begin
                if (m_rem == 0) begin
                    if (m_phase == 0) m_pend = PED_ON && ped_req;
                    m_phase = (m_phase + 1) % 3;
                    m_rem   = dur[m_phase];
                    m_pd    = 1'b1;
                end else if (m_phase == 0 && eff && m_rem > PT) begin
                    m_rem = PT;
                end else begin
                    m_rem = m_rem - 1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        step(); step();
        checks++;
        if ({sel, tens, ones, phase_done} !== {3'b001, 4'd3, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", {sel, tens, ones, phase_done},
                     {3'b001, 4'd3, 4'd5, 1'b0});
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({sel, tens, ones, phase_done} !== {3'b001, 4'd3, 4'd5, 1'b0}) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", i,
                         {sel, tens, ones, phase_done}, {3'b001, 4'd3, 4'd5, 1'b0});
            end
        end
    endtask

    task automatic test_green_countdown();
        bit saw_29 = 1'b0;
        logic [7:0] prev;
        en = 1'b1;
        for (int i = 0; i < 36 * DIV; i++) begin
            prev = {tens, ones};
            step();
            if (prev == 8'h30 && {tens, ones} == 8'h29) saw_29 = 1'b1;
            checks++;
            if ({sel, tens, ones, phase_done} !== exp_vec()) begin
                failures++;
                $display("FAIL green_cnt cyc=%0d got=%h want=%h", i,
                         {sel, tens, ones, phase_done}, exp_vec());
            end
        end
        checks++;
        if (saw_29 !== 1'b1) begin
            failures++;
            $display("FAIL bcd_borrow_30_29 got=%0d want=1", saw_29);
        end
        checks++;
        if ({sel, tens, ones, phase_done} !== {3'b010, 4'd0, 4'd5, 1'b1}) begin
            failures++;
            $display("FAIL green_to_yellow got=%h want=%h", {sel, tens, ones, phase_done},
                     {3'b010, 4'd0, 4'd5, 1'b1});
        end
        step();
        checks++;
        if (phase_done !== 1'b0) begin
            failures++;
            $display("FAIL pd_one_cycle got=%b want=0", phase_done);
        end
    endtask

    task automatic test_full_cycle();
        int pulses = 0;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 73 * DIV; i++) begin
            step();
            if (phase_done === 1'b1) pulses++;
            checks++;
            if ({sel, tens, ones, phase_done} !== exp_vec()) begin
                failures++;
                $display("FAIL full_cycle cyc=%0d got=%h want=%h", i,
                         {sel, tens, ones, phase_done}, exp_vec());
            end
        end
        checks++;
        if (pulses !== 3) begin
            failures++;
            $display("FAIL pd_pulses got=%0d want=3", pulses);
        end
        checks++;
        if ({sel, tens, ones, phase_done} !== {3'b001, 4'd3, 4'd5, 1'b1}) begin
            failures++;
            $display("FAIL cycle_end got=%h want=%h", {sel, tens, ones, phase_done},
                     {3'b001, 4'd3, 4'd5, 1'b1});
        end
    endtask

    task automatic test_en_hold();
        int n = 0;
        do_reset();
        en = 1'b1;
        while (!(tens == 4'd2 && ones == 4'd0) && n < 400) begin step(); n++; end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL en_hold_reach timeout got=%0d%0d want=20", tens, ones);
        end
        step(); step();          // two cycles into the prescale window
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({sel, tens, ones, phase_done} !== {3'b001, 4'd2, 4'd0, 1'b0} ||
                {sel, tens, ones, phase_done} !== exp_vec()) begin
                failures++;
                $display("FAIL en_hold cyc=%0d got=%h want=%h", i,
                         {sel, tens, ones, phase_done}, {3'b001, 4'd2, 4'd0, 1'b0});
            end
        end
        en = 1'b1;
        n = 0;
        while (!(tens == 4'd1 && ones == 4'd9) && n < 20) begin step(); n++; end
        checks++;
        if (n !== DIV - 2) begin
            failures++;
            $display("FAIL en_resume_latency got=%0d want=%0d", n, DIV - 2);
        end
    endtask

    task automatic test_rst_mid_red();
        int n = 0;
        do_reset();
        en = 1'b1;
        while (!(sel == 3'b100 && tens == 4'd1 && ones == 4'd7) && n < 400) begin
            step(); n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL red_reach timeout got=%h want=1_17", {sel, tens, ones});
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({sel, tens, ones, phase_done} !== {3'b001, 4'd3, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid_red got=%h want=%h", {sel, tens, ones, phase_done},
                     {3'b001, 4'd3, 4'd5, 1'b0});
        end
    endtask

`ifdef PED_REQ_EN
    task automatic test_ped();
        int n = 0;
        do_reset();
        en = 1'b1;
        while (!(tens == 4'd2 && ones == 4'd8) && n < 200) begin step(); n++; end
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n = 0;
        while ({tens, ones} == 8'h28 && n < 10) begin step(); n++; end
        checks++;
        if ({sel, tens, ones} !== {3'b001, 4'd1, 4'd0}) begin
            failures++;
            $display("FAIL ped_load got=%h want=%h", {sel, tens, ones}, {3'b001, 8'h10});
        end
        n = 0;
        while (sel != 3'b010 && n < 200) begin
            step(); n++;
            checks++;
            if ({sel, tens, ones, phase_done} !== exp_vec()) begin
                failures++;
                $display("FAIL ped_run got=%h want=%h", {sel, tens, ones, phase_done}, exp_vec());
            end
        end
        checks++;
        if ({sel, tens, ones} !== {3'b010, 4'd0, 4'd5}) begin
            failures++;
            $display("FAIL ped_yellow got=%h want=%h", {sel, tens, ones}, {3'b010, 8'h05});
        end
        n = 0;
        while (!(sel == 3'b001 && tens == 4'd0 && ones == 4'd8) && n < 600) begin
            step(); n++;
        end
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n = 0;
        while ({tens, ones} == 8'h08 && n < 10) begin step(); n++; end
        checks++;
        if ({sel, tens, ones} !== {3'b001, 4'd0, 4'd7}) begin
            failures++;
            $display("FAIL ped_below got=%h want=%h", {sel, tens, ones}, {3'b001, 8'h07});
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            en      = ($urandom_range(0, 9) < 8);
            rst     = ($urandom_range(0, 599) == 0);
            ped_req = PED_ON && ($urandom_range(0, 39) == 0);
            step();
            checks++;
            if ({sel, tens, ones, phase_done} !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", i,
                         {sel, tens, ones, phase_done}, exp_vec());
            end
        end
        rst = 1'b0; ped_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_green_countdown();
        test_full_cycle();
        test_en_hold();
        test_rst_mid_red();
`ifdef PED_REQ_EN
        test_ped();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
